// File: rtl/morse_decoder.sv
// Serial Morse decoder: reads 2-bit symbol pairs (dot, dash, end of character, end of word)
// and presents the ASCII of each completed character, or a space per word gap, on saida.
module morse_decoder (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada,
  output logic [7:0] saida
);

  typedef enum logic {StFirst, StSecond} phase_e;

  phase_e      phase_q, phase_d;
  logic        first_q, first_d;
  logic [4:0]  sym_q, sym_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  saida_q, saida_d;

  // Symbols shift in at bit 0 over a cleared buffer, so bits above the count are always zero
  // and {count, pattern} is an exact table key.
  function automatic logic [7:0] lookup(input logic [2:0] n, input logic [4:0] p);
    case ({n, p})
      8'b001_00000: lookup = 8'h45; // E
      8'b001_00001: lookup = 8'h54; // T
      8'b010_00000: lookup = 8'h49; // I
      8'b010_00001: lookup = 8'h41; // A
      8'b010_00010: lookup = 8'h4E; // N
      8'b010_00011: lookup = 8'h4D; // M
      8'b011_00000: lookup = 8'h53; // S
      8'b011_00001: lookup = 8'h55; // U
      8'b011_00010: lookup = 8'h52; // R
      8'b011_00011: lookup = 8'h57; // W
      8'b011_00100: lookup = 8'h44; // D
      8'b011_00101: lookup = 8'h4B; // K
      8'b011_00110: lookup = 8'h47; // G
      8'b011_00111: lookup = 8'h4F; // O
      8'b100_00000: lookup = 8'h48; // H
      8'b100_00001: lookup = 8'h56; // V
      8'b100_00010: lookup = 8'h46; // F
      8'b100_00100: lookup = 8'h4C; // L
      8'b100_00110: lookup = 8'h50; // P
      8'b100_00111: lookup = 8'h4A; // J
      8'b100_01000: lookup = 8'h42; // B
      8'b100_01001: lookup = 8'h58; // X
      8'b100_01010: lookup = 8'h43; // C
      8'b100_01011: lookup = 8'h59; // Y
      8'b100_01100: lookup = 8'h5A; // Z
      8'b100_01101: lookup = 8'h51; // Q
      8'b101_00000: lookup = 8'h35; // 5
      8'b101_00001: lookup = 8'h34; // 4
      8'b101_00011: lookup = 8'h33; // 3
      8'b101_00111: lookup = 8'h32; // 2
      8'b101_01111: lookup = 8'h31; // 1
      8'b101_10000: lookup = 8'h36; // 6
      8'b101_11000: lookup = 8'h37; // 7
      8'b101_11100: lookup = 8'h38; // 8
      8'b101_11110: lookup = 8'h39; // 9
      8'b101_11111: lookup = 8'h30; // 0
      default:      lookup = 8'h3F; // ?
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= StFirst;
      first_q <= 1'b0;
      sym_q   <= 5'd0;
      cnt_q   <= 3'd0;
      ovf_q   <= 1'b0;
      saida_q <= 8'h00;
    end else begin
      phase_q <= phase_d;
      first_q <= first_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      saida_q <= saida_d;
    end
  end

  always_comb begin
    phase_d = (phase_q == StFirst) ? StSecond : StFirst;
  end

  always_comb begin
    first_d = first_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    saida_d = saida_q;
    if (phase_q == StFirst) begin
      first_d = entrada;
    end else begin
      unique case ({first_q, entrada})
        2'b11, 2'b00: begin
          // Dot shifts in 0, dash shifts in 1; symbols past the fifth only mark overflow.
          if (!ovf_q) begin
            if (cnt_q == 3'd5) begin
              ovf_d = 1'b1;
            end else begin
              sym_d = {sym_q[3:0], ~first_q};
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        2'b10: begin
          if (ovf_q) begin
            saida_d = 8'h3F;
          end else if (cnt_q != 3'd0) begin
            saida_d = lookup(cnt_q, sym_q);
          end
          sym_d = 5'd0;
          cnt_d = 3'd0;
          ovf_d = 1'b0;
        end
        2'b01: begin
          saida_d = 8'h20;
          sym_d   = 5'd0;
          cnt_d   = 3'd0;
          ovf_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign saida = saida_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: the driver queues the expected saida for every clock edge it drives,
// and an independent monitor pops and compares one entry shortly after each rising edge.
module tb_morse_decoder;

  logic       clock;
  logic       reset;
  logic       entrada;
  logic [7:0] saida;

  int unsigned n_vec;
  int unsigned n_err;
  logic [7:0]  exp_q[$];
  logic [7:0]  cur;

  morse_decoder dut (
    .clock   (clock),
    .reset   (reset),
    .entrada (entrada),
    .saida   (saida)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One call per rising edge: drive the bit and record what saida must read after that edge.
  task automatic drive_bit(input logic b, input logic rst, input logic [7:0] e);
    @(negedge clock);
    reset   = rst;
    entrada = b;
    exp_q.push_back(e);
  endtask

  task automatic dot();
    drive_bit(1'b1, 1'b0, cur);
    drive_bit(1'b1, 1'b0, cur);
  endtask

  task automatic dash();
    drive_bit(1'b0, 1'b0, cur);
    drive_bit(1'b0, 1'b0, cur);
  endtask

  task automatic nc(input logic [7:0] e);
    drive_bit(1'b1, 1'b0, cur);
    cur = e;
    drive_bit(1'b0, 1'b0, cur);
  endtask

  task automatic np();
    drive_bit(1'b0, 1'b0, cur);
    cur = 8'h20;
    drive_bit(1'b1, 1'b0, cur);
  endtask

  // Monitor
  initial begin
    logic [7:0] e;
    int unsigned edge_no;
    edge_no = 0;
    forever begin
      @(posedge clock);
      #1;
      edge_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (saida !== e) begin
          n_err++;
          $display("FAIL saida at edge %0d: got %h, expected %h", edge_no, saida, e);
        end
      end
    end
  end

  // Driver
  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    entrada = 1'b0;
    cur     = 8'h00;

    drive_bit(1'b0, 1'b1, 8'h00);
    drive_bit(1'b0, 1'b1, 8'h00);

    // E: stays 0x00 until the 4th edge after reset release
    dot(); nc(8'h45);

    // E A I <sp> M A N I N H O
    dot(); dash(); nc(8'h41);
    dot(); dot(); nc(8'h49);
    np();
    dash(); dash(); nc(8'h4D);
    dot(); dash(); nc(8'h41);
    dash(); dot(); nc(8'h4E);
    dot(); dot(); nc(8'h49);
    dash(); dot(); nc(8'h4E);
    dot(); dot(); dot(); dot(); nc(8'h48);
    dash(); dash(); dash(); nc(8'h4F);

    // Overflow, then proof that the buffer cleared
    for (int i = 0; i < 6; i++) dot();
    nc(8'h3F);
    dot(); nc(8'h45);

    for (int i = 0; i < 5; i++) dash();
    nc(8'h30);
    dot(); for (int i = 0; i < 4; i++) dash();
    nc(8'h31);
    for (int i = 0; i < 5; i++) dot();
    nc(8'h35);

    // Empty NC holds; unlisted code gives '?'
    nc(8'h35);
    dot(); dot(); dash(); dash(); nc(8'h3F);

    // Word gap discards pending symbols
    dash(); dot(); np();
    nc(8'h20);
    dash(); dash(); dash(); dash(); dot(); nc(8'h39);
    dash(); dot(); dash(); nc(8'h4B);

    // Reset mid-pair after 'A'
    dot(); dash(); nc(8'h41);
    drive_bit(1'b1, 1'b0, cur);
    cur = 8'h00;
    drive_bit(1'b1, 1'b1, cur);
    dash(); nc(8'h54);

    repeat (4) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
